// File: rtl/line_fill_ctrl.sv
// Cache line refill engine: fetches a 64-bit line as two 32-bit beats and writes line + tag.
// Optional macro CRITICAL_WORD_FIRST_EN fetches the word holding the missed address first.
module line_fill_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              fill,
  output logic [4:0]        idx_mem,
  output logic [63:0]       data_mem,
  output logic              tag_we,
  output logic [ADDR_W-9:0] tag_out,
  output logic              err
);
  // Memory handshake: a beat completes in the cycle where mem_req=1 and mem_ack=1;
  // mem_req/mem_addr stay stable until then, and mem_ack with mem_req=0 is ignored.
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, FILL} state_t;

  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

  state_t            state, state_nx;
  logic [ADDR_W-9:0] tag_q, tag_nx;
  logic [4:0]        idx_q, idx_nx;
  logic              first_q, first_nx;
  logic [63:0]       line_q, line_nx, line_upd;
  logic [7:0]        cnt_q, cnt_nx;
  logic [8:0]        cnt_inc;
  logic              req_first;
  logic              unused_bits;

  logic              busy_nx, mem_req_nx, fill_nx, tag_we_nx, err_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [4:0]        idx_mem_nx;
  logic [63:0]       data_mem_nx;
  logic [ADDR_W-9:0] tag_out_nx;

`ifdef CRITICAL_WORD_FIRST_EN
  assign req_first = req_addr[2];
`else
  assign req_first = 1'b0;
`endif
  assign unused_bits = ^req_addr[2:0];
  assign cnt_inc     = {1'b0, cnt_q} + 9'd1;

  always_comb begin
    state_nx    = state;
    tag_nx      = tag_q;
    idx_nx      = idx_q;
    first_nx    = first_q;
    line_nx     = line_q;
    cnt_nx      = cnt_q;
    busy_nx     = busy;
    mem_req_nx  = mem_req;
    mem_addr_nx = mem_addr;
    fill_nx     = 1'b0;
    tag_we_nx   = 1'b0;
    err_nx      = 1'b0;
    idx_mem_nx  = idx_mem;
    data_mem_nx = data_mem;
    tag_out_nx  = tag_out;

    // Slot for the returning beat follows the word address actually requested.
    line_upd = line_q;
    if (mem_addr[2]) line_upd[63:32] = mem_rdata;
    else             line_upd[31:0]  = mem_rdata;

    case (state)
      IDLE: begin
        if (req_valid) begin
          tag_nx      = req_addr[ADDR_W-1:8];
          idx_nx      = req_addr[7:3];
          first_nx    = req_first;
          cnt_nx      = 8'd0;
          busy_nx     = 1'b1;
          mem_req_nx  = 1'b1;
          mem_addr_nx = {req_addr[ADDR_W-1:3], req_first, 2'b00};
          state_nx    = BEAT0;
        end
      end
      BEAT0, BEAT1: begin
        if (!mem_req) begin
          // Gap cycle after beat 0: issue the second word.
          mem_req_nx  = 1'b1;
          mem_addr_nx = {tag_q, idx_q, ~first_q, 2'b00};
        end else if (mem_ack) begin
          mem_req_nx = 1'b0;
          cnt_nx     = 8'd0;
          line_nx    = line_upd;
          if (state == BEAT0) begin
            state_nx = BEAT1;
          end else begin
            state_nx    = FILL;
            fill_nx     = 1'b1;
            tag_we_nx   = 1'b1;
            idx_mem_nx  = idx_q;
            tag_out_nx  = tag_q;
            data_mem_nx = line_upd;
          end
        end else if (cnt_inc >= TIMEOUT_LIM) begin
          mem_req_nx = 1'b0;
          err_nx     = 1'b1;
          busy_nx    = 1'b0;
          cnt_nx     = 8'd0;
          state_nx   = IDLE;
        end else begin
          cnt_nx = (cnt_q == 8'hFF) ? cnt_q : cnt_inc[7:0];
        end
      end
      FILL: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tag_q    <= '0;
      idx_q    <= '0;
      first_q  <= 1'b0;
      line_q   <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      fill     <= 1'b0;
      tag_we   <= 1'b0;
      err      <= 1'b0;
      idx_mem  <= '0;
      data_mem <= '0;
      tag_out  <= '0;
    end else begin
      state    <= state_nx;
      tag_q    <= tag_nx;
      idx_q    <= idx_nx;
      first_q  <= first_nx;
      line_q   <= line_nx;
      cnt_q    <= cnt_nx;
      busy     <= busy_nx;
      mem_req  <= mem_req_nx;
      mem_addr <= mem_addr_nx;
      fill     <= fill_nx;
      tag_we   <= tag_we_nx;
      err      <= err_nx;
      idx_mem  <= idx_mem_nx;
      data_mem <= data_mem_nx;
      tag_out  <= tag_out_nx;
    end
  end
endmodule

// File: tb/tb_line_fill_ctrl.sv
// Self-checking bench for line_fill_ctrl: directed and randomized refills against a memory-image model.
`timescale 1ns/1ps
module tb_line_fill_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, mem_ack, busy, mem_req, fill, tag_we, err;
  logic [31:0] req_addr, mem_addr, mem_rdata;
  logic [4:0]  idx_mem;
  logic [63:0] data_mem;
  logic [23:0] tag_out;

  logic        req_valid_t, mem_ack_t, busy_t, mem_req_t, fill_t, tag_we_t, err_t;
  logic [31:0] req_addr_t, mem_addr_t, mem_rdata_t;
  logic [4:0]  idx_mem_t;
  logic [63:0] data_mem_t;
  logic [23:0] tag_out_t;

  line_fill_ctrl #(.TIMEOUT(255), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .fill(fill), .idx_mem(idx_mem), .data_mem(data_mem),
    .tag_we(tag_we), .tag_out(tag_out), .err(err)
  );

  line_fill_ctrl #(.TIMEOUT(4), .ADDR_W(32)) dut_t (
    .clk(clk), .reset(reset), .req_valid(req_valid_t), .req_addr(req_addr_t),
    .busy(busy_t), .mem_req(mem_req_t), .mem_addr(mem_addr_t), .mem_ack(mem_ack_t),
    .mem_rdata(mem_rdata_t), .fill(fill_t), .idx_mem(idx_mem_t), .data_mem(data_mem_t),
    .tag_we(tag_we_t), .tag_out(tag_out_t), .err(err_t)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_img [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Precondition: req_valid/req_addr were just driven (after a posedge) with the DUT idle.
  task automatic refill(input logic [31:0] addr, input int d0, input int d1,
                        input bit keep, input logic [31:0] next_addr);
    logic [31:0] base, held;
    logic        first;
    int          delays [2];
    int          cyc, beat, wait_n, dly;
    bit          done, in_req, err_seen, busy_low, we_early;
    base = {addr[31:3], 3'b000};
`ifdef CRITICAL_WORD_FIRST_EN
    first = addr[2];
`else
    first = 1'b0;
`endif
    exp_q.delete();
    exp_q.push_back(base | {29'd0, first, 2'b00});
    exp_q.push_back(base | {29'd0, ~first, 2'b00});
    delays[0] = d0; delays[1] = d1;
    cyc = 0; beat = 0; wait_n = 0; held = '0;
    done = 0; in_req = 0; err_seen = 0; busy_low = 0; we_early = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      mem_ack = 1'b0;
      if (!keep) begin
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
      end
      err_seen |= err;
      if (!busy) busy_low = 1;
      if (fill) begin
        done = 1;
        chk("fill_cycle", 64'(cyc), 64'(4 + d0 + d1));
        chk("beats_before_fill", 64'(beat), 64'd2);
        chk("fill_idx", 64'(idx_mem), 64'(addr[7:3]));
        chk("fill_tag", 64'(tag_out), 64'(addr[31:8]));
        chk("fill_data", data_mem, {mem_word(base | 32'd4), mem_word(base)});
        chk("fill_tag_we", 64'(tag_we), 64'd1);
      end else begin
        if (tag_we) we_early = 1;
        if (mem_req) begin
          if (!in_req) begin
            in_req = 1; held = mem_addr; wait_n = 0;
            if (exp_q.size() == 0) chk("beat_count", 64'(beat + 1), 64'd2);
            else chk("mem_addr", 64'(mem_addr), 64'(exp_q.pop_front()));
          end
          chk("mem_addr_stable", 64'(mem_addr), 64'(held));
          dly = (beat < 2) ? delays[beat] : 0;
          if (wait_n == dly) begin
            mem_ack = 1'b1; mem_rdata = mem_word(mem_addr); in_req = 0; beat++;
          end else begin
            wait_n++; mem_rdata = $urandom;
          end
        end else begin
          if (in_req) chk("mem_req_held", 64'(mem_req), 64'd1);
          mem_ack   = 1'($urandom_range(0, 1));
          mem_rdata = $urandom;
        end
      end
    end
    chk("fill_seen", 64'(done), 64'd1);
    chk("no_err", 64'(err_seen), 64'd0);
    chk("busy_during", 64'(busy_low), 64'd0);
    chk("no_early_tag_we", 64'(we_early), 64'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    if (keep) req_addr = next_addr;
    else      req_valid = 1'b0;
    chk("busy_after", 64'(busy), 64'd0);
    chk("single_fill", 64'({fill, tag_we, err}), 64'd0);
  endtask

  initial begin
    int rise, err_at, nerr, w;
    bit fill_seen, err_seen, any_out;
    logic [31:0] a;
    reset = 1'b1;
    req_valid = 0; req_addr = '0; mem_ack = 0; mem_rdata = '0;
    req_valid_t = 0; req_addr_t = '0; mem_ack_t = 0; mem_rdata_t = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 64'({busy, mem_req, fill, tag_we, err}), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    chk("reset_fill_bus", {data_mem[63:29], idx_mem, tag_out}, 64'd0);
    reset = 1'b0;

    // Basic refill with known data
    mem_img[32'h0000_1238] = 32'hAAAA_0000;
    mem_img[32'h0000_123C] = 32'hBBBB_1111;
    @(posedge clk); #1; req_valid = 1; req_addr = 32'h0000_1238;
    refill(32'h0000_1238, 0, 0, 0, 32'h0);
    chk("basic_data_literal", data_mem, 64'hBBBB_1111_AAAA_0000);
    @(posedge clk); #1; req_valid = 1; req_addr = 32'h0000_123C;
    refill(32'h0000_123C, 0, 0, 0, 32'h0);
    chk("cwf_data_literal", data_mem, 64'hBBBB_1111_AAAA_0000);

    // Stalled memory on beat 0
    @(posedge clk); #1; req_valid = 1; req_addr = 32'h0000_1238;
    refill(32'h0000_1238, 10, 0, 0, 32'h0);

    // Back-to-back with req_valid held high
    @(posedge clk); #1; req_valid = 1; req_addr = 32'h0000_0040;
    refill(32'h0000_0040, 1, 0, 1, 32'h0000_0048);
    refill(32'h0000_0048, 0, 2, 0, 32'h0);

    // Randomized refills
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      mem_img[{a[31:3], 3'b000}] = $urandom;
      mem_img[{a[31:3], 3'b100}] = $urandom;
      @(posedge clk); #1; req_valid = 1; req_addr = a;
      refill(a, $urandom_range(0, 6), $urandom_range(0, 6), 0, 32'h0);
    end

    // Reset during beat 1, then a stray ack
    @(posedge clk); #1; req_valid = 1; req_addr = 32'h0000_5A18;
    @(posedge clk); #1; req_valid = 0;
    chk("rst_beat0_req", 64'(mem_req), 64'd1);
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1; mem_ack = 0;
    @(posedge clk); #1;
    chk("rst_beat1_req", 64'(mem_req), 64'd1);
    reset = 1;
    @(posedge clk); #1; reset = 0; mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    chk("rst_mid_ctrl", 64'({busy, mem_req, fill, tag_we, err}), 64'd0);
    chk("rst_mid_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mid_data", data_mem, 64'd0);
    chk("rst_mid_idx_tag", 64'({idx_mem, tag_out}), 64'd0);
    any_out = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1; mem_ack = 0;
      if (busy || mem_req || fill || tag_we || err) any_out = 1;
    end
    chk("rst_stray_ack_ignored", 64'(any_out), 64'd0);

    // Timeout with TIMEOUT=4, no ack ever
    @(posedge clk); #1; req_valid_t = 1; req_addr_t = 32'h0000_0A40;
    rise = -1; err_at = -1; nerr = 0; fill_seen = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1; req_valid_t = 0;
      if (mem_req_t && rise < 0) rise = c;
      if (err_t) begin
        nerr++; err_at = c;
        chk("to_mem_req_low", 64'(mem_req_t), 64'd0);
      end
      if (fill_t || tag_we_t) fill_seen = 1;
    end
    chk("to_err_count", 64'(nerr), 64'd1);
    chk("to_err_delay", 64'(err_at - rise), 64'd4);
    chk("to_no_fill", 64'(fill_seen), 64'd0);
    chk("to_busy_low", 64'({busy_t, mem_req_t}), 64'd0);
    req_valid_t = 1; req_addr_t = 32'h0000_0A48;
    @(posedge clk); #1; req_valid_t = 0;
    chk("to_new_req_busy", 64'(busy_t), 64'd1);
    chk("to_new_req_addr", 64'(mem_addr_t), 64'h0A48);

    // Ack in the cycle the count reaches TIMEOUT: success
    w = 0; fill_seen = 0; err_seen = 0;
    for (int c = 0; c < 30; c++) begin
      mem_ack_t = 0;
      if (mem_req_t) begin
        if (w == 3) begin mem_ack_t = 1; mem_rdata_t = $urandom; w = 0; end
        else w++;
      end
      if (fill_t) fill_seen = 1;
      if (err_t) err_seen = 1;
      @(posedge clk); #1;
    end
    mem_ack_t = 0;
    chk("ack_wins_fill", 64'(fill_seen), 64'd1);
    chk("ack_wins_no_err", 64'(err_seen), 64'd0);
    chk("ack_wins_idx", 64'(idx_mem_t), 64'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
